// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU behind a start/done handshake.
// Single-cycle ops complete one edge after start. When DIV_ENABLE = 1, DIVU/REMU
// run on an iterative restoring divider that needs WIDTH cycles, and busy is
// high while it works.
module alu_seq #(
    parameter int WIDTH      = 32,
    parameter int DIV_ENABLE = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic             is_zero,
    output logic             is_negative,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W   = $clog2(WIDTH);
    localparam logic             HAS_DIV = (DIV_ENABLE != 0);
    localparam logic [WIDTH-1:0] W_VAL   = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   dvd_r;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   dvs_r;
    logic [WIDTH-1:0]   rem_r;
    logic               op_rem_r;     // 1 = REMU, 0 = DIVU
    logic [WIDTH-1:0]   c_r;
    logic               is_zero_r;
    logic               is_negative_r;
    logic               div_by_zero_r;
    logic               busy_r;
    logic               done_r;

    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   diff_s;
    logic [WIDTH-1:0]   alu_s;
    logic               is_div_op_s;
    logic [WIDTH:0]     trial_s;
    logic [WIDTH-1:0]   rem_next_s;
    logic               qbit_s;
    logic [WIDTH-1:0]   div_res_s;

    // Count leading zeros; an all-zero value yields WIDTH.
    function automatic logic [WIDTH-1:0] clz(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] n;
        logic             found;
        n     = {WIDTH{1'b0}};
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (found) begin
                n = n;
            end else if (v[i]) begin
                found = 1'b1;
            end else begin
                n = n + WIDTH'(1);
            end
        end
        return n;
    endfunction

    assign c           = c_r;
    assign is_zero     = is_zero_r;
    assign is_negative = is_negative_r;
    assign div_by_zero = div_by_zero_r;
    assign busy        = busy_r;
    assign done        = done_r;

    // Single-cycle result for the operands currently on the inputs.
    always_comb begin
        prod_s      = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        diff_s      = a - b;
        is_div_op_s = (op == 4'd2) || (op == 4'd3);
        alu_s       = {WIDTH{1'b0}};
        case (op)
            4'd0:  alu_s = a + b;
            4'd1:  alu_s = diff_s;
            4'd4:  alu_s = a & b;
            4'd5:  alu_s = a | b;
            4'd6:  alu_s = a ^ b;
            4'd7:  alu_s = ~a;
            4'd8: begin
                if (diff_s[WIDTH-1]) begin
                    alu_s = {WIDTH{1'b1}};
                end else if (a == b) begin
                    alu_s = {WIDTH{1'b0}};
                end else begin
                    alu_s = WIDTH'(1);
                end
            end
            4'd9:  alu_s = a;
            4'd10: alu_s = clz(a);
            4'd11: begin
                if (b >= W_VAL) begin
                    alu_s = {WIDTH{a[WIDTH-1]}};
                end else begin
                    alu_s = $signed(a) >>> b;
                end
            end
            4'd12: begin
                if (b >= W_VAL) begin
                    alu_s = {WIDTH{1'b0}};
                end else begin
                    alu_s = a << b;
                end
            end
            4'd13: begin
                if (b >= W_VAL) begin
                    alu_s = {WIDTH{1'b0}};
                end else begin
                    alu_s = a >> b;
                end
            end
            4'd14: alu_s = prod_s[WIDTH-1:0];
            4'd15: alu_s = prod_s[2*WIDTH-1:WIDTH];
            default: alu_s = {WIDTH{1'b0}};    // ops 2/3 without a divider
        endcase
    end

    // One restoring shift-subtract step; the borrow bit says whether to restore.
    always_comb begin
        trial_s = {rem_r, dvd_r[WIDTH-1]} - {1'b0, dvs_r};
        if (!trial_s[WIDTH]) begin
            rem_next_s = trial_s[WIDTH-1:0];
            qbit_s     = 1'b1;
        end else begin
            rem_next_s = {rem_r[WIDTH-2:0], dvd_r[WIDTH-1]};
            qbit_s     = 1'b0;
        end
        if (op_rem_r) begin
            div_res_s = rem_next_s;
        end else begin
            div_res_s = {dvd_r[WIDTH-2:0], qbit_s};
        end
    end

    // Control FSM, divider datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            dvd_r         <= {WIDTH{1'b0}};
            dvs_r         <= {WIDTH{1'b0}};
            rem_r         <= {WIDTH{1'b0}};
            op_rem_r      <= 1'b0;
            c_r           <= {WIDTH{1'b0}};
            is_zero_r     <= 1'b1;
            is_negative_r <= 1'b0;
            div_by_zero_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && HAS_DIV && is_div_op_s) begin
                        dvd_r    <= a;
                        dvs_r    <= b;
                        rem_r    <= {WIDTH{1'b0}};
                        cnt_r    <= {CNT_W{1'b0}};
                        op_rem_r <= op[0];
                        busy_r   <= 1'b1;
                        state_r  <= ST_DIV;
                    end else if (start) begin
                        c_r           <= alu_s;
                        is_zero_r     <= (alu_s == {WIDTH{1'b0}});
                        is_negative_r <= alu_s[WIDTH-1];
                        div_by_zero_r <= 1'b0;
                        done_r        <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DIV: begin
                    dvd_r <= {dvd_r[WIDTH-2:0], qbit_s};
                    rem_r <= rem_next_s;
                    if (cnt_r == CNT_END) begin
                        c_r           <= div_res_s;
                        is_zero_r     <= (div_res_s == {WIDTH{1'b0}});
                        is_negative_r <= div_res_s[WIDTH-1];
                        div_by_zero_r <= (dvs_r == {WIDTH{1'b0}});
                        done_r        <= 1'b1;
                        busy_r        <= 1'b0;
                        cnt_r         <= {CNT_W{1'b0}};
                        state_r       <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
